dpu_pipe: RTL and testbench
===========================

# dpu_pipe

Clocked, parametrised datapath unit for the CCU: a DEPTH×WIDTH register file with an integrated ALU, a one-deep execute pipeline, a valid/ready instruction port, and a buffered pixel output port. It replaces the combinational DPU by registering every state change on one clock edge. Pixel words (X, Y, colour) are emitted only on an explicit EMIT instruction, through a handshake, so the video path can stall the sequencer.

## Interface
- WIDTH, 8: datapath and register width in bits (≥4).
- DEPTH, 16: number of registers (power of two, ≥16); AW = clog2(DEPTH).
- X_IDX / Y_IDX / C_IDX, 9 / 10 / 11: register indices forming the pixel word.
- ONE_IDX, 12: register reset to 1; all other registers reset to 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted this cycle when high with in_valid.
- op  in  4  opcode.
- a_sel, b_sel, r_sel  in  AW  source A, source B and destination register.
- mdata  in  WIDTH  load data for LOAD.
- cc  out  4  condition codes {N,Z,C,V}.
- pix_valid  out  1  pixel word valid.
- pix_ready  in  1  consumer accepts the pixel word.
- pix_data  out  3*WIDTH  {reg[X_IDX], reg[Y_IDX], reg[C_IDX]} as captured at EMIT.

## Operation
- Opcodes: 0 NOP; 1 ADD A+B; 2 SUB A−B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<1; 7 SHR A>>1 (logical); 8 LOAD R←mdata; 9 MOV R←A; 10 INC A+1; 11 DEC A−1; 12 EMIT; 13 CMP (A−B, cc only, no write); 14–15 NOP.
- Accepted instruction (in_valid && in_ready) is latched into the execute stage with operands read in the same cycle.
- Execute stage computes the result at WIDTH bits; the carry-out is bit WIDTH of the (WIDTH+1)-bit sum/difference; SUB/CMP/DEC C = borrow-free (1 when A ≥ subtrahend). V = signed overflow for ADD/SUB/CMP/INC/DEC, else 0. N = result MSB, Z = result == 0.
- cc updates only for ops 1–7, 10, 11, 13; LOAD, MOV, NOP, EMIT leave cc unchanged.
- Writes to r_sel for ops 1–11; every register, including ONE_IDX, is writable.
- EMIT: captures pix_data from register state including any write completing the same cycle; sets pix_valid.
- Pixel buffer is one entry: pix_valid held, pix_data stable, until pix_valid && pix_ready.
- in_ready is low when op==EMIT is presented while the buffer is full and not draining this cycle; otherwise high, except the hazard stall (Configuration).
- Reset mid-operation: the execute stage is squashed (no write, no cc update), the pixel buffer is dropped, and the registers reinitialise.

## Timing
- Reset values: in_ready 1, cc 4'b0000, pix_valid 0, pix_data 0, registers 0 except reg[ONE_IDX]=1.
- Accept in cycle t → register write and cc valid after edge t+1 (latency 1 cycle, throughput 1/cycle).
- EMIT accepted in cycle t → pix_valid high from edge t+1; a pixel accepted by the consumer and a new EMIT in the same cycle keeps pix_valid high with the new data (no bubble).
- Simultaneous pixel drain and new-EMIT stall check: a drain in the same cycle frees the slot, so in_ready stays 1.

## Configuration
- DPU_FORWARD_EN defined: the execute-stage result bypasses to the a/b operand read when a_sel or b_sel equals the pending destination; no hazard stalls; back-to-back dependent ops run at 1/cycle.
- Undefined: in_ready is forced low for one cycle when the presented instruction reads (A or B, including EMIT's X/Y/C indices) the pending destination; the instruction issues the next cycle with the written value.

## Test plan
- Reset → cc=0, pix_valid=0, reg[12]=1; MOV r0←r12, then EMIT with X/Y/C set to 0 → pix_data=0.
- LOAD r1←8'hFF, LOAD r2←8'h01, ADD r3=r1+r2 → r3=8'h00, cc={N0,Z1,C1,V0}.
- LOAD r9←5, r10←7, r11←8'hA3, EMIT with pix_ready=0 for 3 cycles → pix_data=24'h0507A3 stable, second EMIT stalls until pix_ready=1.
- Dependent chain INC r4←r4 ×4 back-to-back → r4=4; with DPU_FORWARD_EN takes 4 accept cycles, without takes 7.
- LOAD r5←8'h7F, INC r6←r5 → r6=8'h80, V=1, N=1; CMP r5,r5 → Z=1, C=1, no register written.
- Assert rst on the cycle after ADD accept with pix_valid=1 → no write occurs, pix_valid=0, all registers at reset values.

Source files
------------

// File: rtl/dpu_pipe.sv
// dpu_pipe: DEPTHxWIDTH register file with ALU, one-deep writeback stage, valid/ready
// instruction port and one-entry pixel buffer. Macro DPU_FORWARD_EN selects operand bypass over hazard stalls.
module dpu_pipe #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int X_IDX   = 9,
    parameter int Y_IDX   = 10,
    parameter int C_IDX   = 11,
    parameter int ONE_IDX = 12,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [AW-1:0]      a_sel,
    input  logic [AW-1:0]      b_sel,
    input  logic [AW-1:0]      r_sel,
    input  logic [WIDTH-1:0]   mdata,
    output logic [3:0]         cc,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [3*WIDTH-1:0] pix_data
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_LOAD = 4'd8;
    localparam logic [3:0] OP_MOV  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_EMIT = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;

    localparam logic [AW-1:0]    X_SEL = AW'(X_IDX);
    localparam logic [AW-1:0]    Y_SEL = AW'(Y_IDX);
    localparam logic [AW-1:0]    C_SEL = AW'(C_IDX);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0]   regs_r [DEPTH];
    logic               ex_wr_r;
    logic [AW-1:0]      ex_rd_r;
    logic [WIDTH-1:0]   ex_res_r;
    logic [3:0]         cc_r;
    logic               pix_valid_r;
    logic [3*WIDTH-1:0] pix_data_r;

    logic [WIDTH-1:0] a_val_s, b_val_s, x_val_s, y_val_s, c_val_s;
    logic [WIDTH:0]   add_s, sub_s, inc_s, dec_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s, v_s, wr_s, upd_s, emit_s, use_a_s, use_b_s;
    logic             hazard_s, in_ready_s, accept_s;

`ifdef DPU_FORWARD_EN
    // The pending writeback result overrides the stale register file copy.
    assign a_val_s = (ex_wr_r && (ex_rd_r == a_sel)) ? ex_res_r : regs_r[a_sel];
    assign b_val_s = (ex_wr_r && (ex_rd_r == b_sel)) ? ex_res_r : regs_r[b_sel];
    assign x_val_s = (ex_wr_r && (ex_rd_r == X_SEL)) ? ex_res_r : regs_r[X_SEL];
    assign y_val_s = (ex_wr_r && (ex_rd_r == Y_SEL)) ? ex_res_r : regs_r[Y_SEL];
    assign c_val_s = (ex_wr_r && (ex_rd_r == C_SEL)) ? ex_res_r : regs_r[C_SEL];
    assign hazard_s = 1'b0;
`else
    assign a_val_s = regs_r[a_sel];
    assign b_val_s = regs_r[b_sel];
    assign x_val_s = regs_r[X_SEL];
    assign y_val_s = regs_r[Y_SEL];
    assign c_val_s = regs_r[C_SEL];

    // Hold off any instruction that reads the register still waiting to be written.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_wr_r) begin
            hazard_s = (use_a_s && (ex_rd_r == a_sel)) ||
                       (use_b_s && (ex_rd_r == b_sel)) ||
                       (emit_s && ((ex_rd_r == X_SEL) || (ex_rd_r == Y_SEL) || (ex_rd_r == C_SEL)));
        end else begin
            hazard_s = 1'b0;
        end
    end
`endif

    assign add_s = {1'b0, a_val_s} + {1'b0, b_val_s};
    assign sub_s = {1'b0, a_val_s} - {1'b0, b_val_s};
    assign inc_s = {1'b0, a_val_s} + {1'b0, ONE_W};
    assign dec_s = {1'b0, a_val_s} - {1'b0, ONE_W};

    // Decode and ALU; subtract-type carry is the inverted borrow.
    always_comb begin
        res_s   = '0;
        c_s     = 1'b0;
        v_s     = 1'b0;
        wr_s    = 1'b0;
        upd_s   = 1'b0;
        emit_s  = 1'b0;
        use_a_s = 1'b0;
        use_b_s = 1'b0;
        case (op)
            OP_ADD:  begin res_s = add_s[WIDTH-1:0]; c_s = add_s[WIDTH];
                           v_s = add_ovf(a_val_s, b_val_s, add_s[WIDTH-1:0]);
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            OP_SUB:  begin res_s = sub_s[WIDTH-1:0]; c_s = ~sub_s[WIDTH];
                           v_s = sub_ovf(a_val_s, b_val_s, sub_s[WIDTH-1:0]);
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            OP_AND:  begin res_s = a_val_s & b_val_s;
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            OP_OR:   begin res_s = a_val_s | b_val_s;
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            OP_XOR:  begin res_s = a_val_s ^ b_val_s;
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            OP_SHL:  begin res_s = {a_val_s[WIDTH-2:0], 1'b0};
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; end
            OP_SHR:  begin res_s = {1'b0, a_val_s[WIDTH-1:1]};
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; end
            OP_LOAD: begin res_s = mdata; wr_s = 1'b1; end
            OP_MOV:  begin res_s = a_val_s; wr_s = 1'b1; use_a_s = 1'b1; end
            OP_INC:  begin res_s = inc_s[WIDTH-1:0]; c_s = inc_s[WIDTH];
                           v_s = add_ovf(a_val_s, ONE_W, inc_s[WIDTH-1:0]);
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; end
            OP_DEC:  begin res_s = dec_s[WIDTH-1:0]; c_s = ~dec_s[WIDTH];
                           v_s = sub_ovf(a_val_s, ONE_W, dec_s[WIDTH-1:0]);
                           wr_s = 1'b1; upd_s = 1'b1; use_a_s = 1'b1; end
            OP_EMIT: begin emit_s = 1'b1; end
            OP_CMP:  begin res_s = sub_s[WIDTH-1:0]; c_s = ~sub_s[WIDTH];
                           v_s = sub_ovf(a_val_s, b_val_s, sub_s[WIDTH-1:0]);
                           upd_s = 1'b1; use_a_s = 1'b1; use_b_s = 1'b1; end
            default: begin res_s = '0; end
        endcase
    end

    // An EMIT may only enter if the pixel slot is empty or drains on this same edge.
    always_comb begin
        if (in_valid && ((emit_s && pix_valid_r && !pix_ready) || hazard_s)) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Register file: reset image, then writeback from the pending stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == ONE_IDX) ? ONE_W : '0;
            end
        end else if (ex_wr_r) begin
            regs_r[ex_rd_r] <= ex_res_r;
        end
    end

    // Pending writeback stage and condition codes; reset squashes the pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wr_r  <= 1'b0;
            ex_rd_r  <= '0;
            ex_res_r <= '0;
            cc_r     <= 4'b0000;
        end else begin
            ex_wr_r <= accept_s && wr_s;
            if (accept_s) begin
                ex_rd_r  <= r_sel;
                ex_res_r <= res_s;
                if (upd_s) begin
                    cc_r <= {res_s[WIDTH-1], ~|res_s, c_s, v_s};
                end
            end
        end
    end

    // One-entry pixel buffer; a refill on the draining edge avoids a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= '0;
        end else if (accept_s && emit_s) begin
            pix_valid_r <= 1'b1;
            pix_data_r  <= {x_val_s, y_val_s, c_val_s};
        end else if (pix_ready) begin
            pix_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign cc        = cc_r;
    assign pix_valid = pix_valid_r;
    assign pix_data  = pix_data_r;

endmodule

// File: tb/tb_dpu_pipe.sv
// tb_dpu_pipe: directed plus random stimulus for dpu_pipe, checked every cycle against an
// architectural model of the register file, condition codes and pixel slot.
module tb_dpu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [3:0]  a_sel = 4'd0, b_sel = 4'd0, r_sel = 4'd0;
    logic [7:0]  mdata = 8'd0;
    logic [3:0]  cc;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [23:0] pix_data;

    dpu_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_sel(a_sel), .b_sel(b_sel), .r_sel(r_sel), .mdata(mdata), .cc(cc),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;

    int          m_regs [16];
    logic [3:0]  m_cc;
    bit          m_pv;
    logic [23:0] m_pd;
    bit          m_pend_v;
    logic [3:0]  m_pend_rd;
    bit          m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        bit em, ra, rb;
        em = (op == 4'd12);
        ra = (op >= 4'd1 && op <= 4'd7) || op == 4'd9 || op == 4'd10 || op == 4'd11 || op == 4'd13;
        rb = (op >= 4'd1 && op <= 4'd5) || op == 4'd13;
        if (!in_valid) return 1'b1;
        if (em && m_pv && !pix_ready) return 1'b0;
`ifndef DPU_FORWARD_EN
        if (m_pend_v && ((ra && a_sel == m_pend_rd) || (rb && b_sel == m_pend_rd) ||
                         (em && (m_pend_rd == 4'd9 || m_pend_rd == 4'd10 || m_pend_rd == 4'd11))))
            return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Architectural effect of one clock edge, from the values presented before it.
    task automatic model_tick();
        int a, b, res, sa, sb, sr;
        bit c, v, wr, upd, acc;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = (i == 12) ? 1 : 0;
            m_cc = 4'b0000; m_pv = 1'b0; m_pd = 24'h0; m_pend_v = 1'b0; m_acc = 1'b0;
        end else begin
            acc = in_valid && model_ready();
            m_acc = acc;
            a = m_regs[a_sel];
            b = (op == 4'd10 || op == 4'd11) ? 1 : m_regs[b_sel];
            sa = (a > 127) ? a - 256 : a;
            sb = (b > 127) ? b - 256 : b;
            res = 0; c = 1'b0; v = 1'b0;
            wr = (op >= 4'd1 && op <= 4'd11);
            upd = (op >= 4'd1 && op <= 4'd7) || op == 4'd10 || op == 4'd11 || op == 4'd13;
            case (op)
                4'd1, 4'd10:        begin res = (a + b) % 256; c = (a + b) > 255;
                                          sr = sa + sb; v = (sr > 127) || (sr < -128); end
                4'd2, 4'd11, 4'd13: begin res = (a - b + 256) % 256; c = (a >= b);
                                          sr = sa - sb; v = (sr > 127) || (sr < -128); end
                4'd3: res = a & b;
                4'd4: res = a | b;
                4'd5: res = a ^ b;
                4'd6: res = (a * 2) % 256;
                4'd7: res = a / 2;
                4'd8: res = int'(mdata);
                4'd9: res = a;
                default: res = 0;
            endcase
            if (m_pv && pix_ready) m_pv = 1'b0;
            if (acc) begin
                if (upd) m_cc = {res > 127, res == 0, c, v};
                if (op == 4'd12) begin
                    m_pd = {8'(m_regs[9]), 8'(m_regs[10]), 8'(m_regs[11])};
                    m_pv = 1'b1;
                end
                if (wr) m_regs[r_sel] = res;
            end
            m_pend_v = acc && wr;
            m_pend_rd = r_sel;
        end
    endtask

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(model_ready()));
            check("cc", 32'(cc), 32'(m_cc));
            check("pix_valid", 32'(pix_valid), 32'(m_pv));
            check("pix_data", 32'(pix_data), 32'(m_pd));
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_tick();
        cyc++;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] r, input logic [7:0] md);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; op = o; a_sel = a; b_sel = b; r_sel = r; mdata = md;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            got = m_acc;
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        cycle(); cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_cc", 32'(cc), 32'h0);
        check("reset_pix_valid", 32'(pix_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);

        // ONE register reset value and zero pixel
        issue(4'd9, 4'd12, 4'd0, 4'd0, 8'h00);
        idle();
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("emit_zero", 32'(pix_data), 32'h0);
        check("emit_zero_valid", 32'(pix_valid), 32'h1);
        issue(4'd9, 4'd0, 4'd0, 4'd9, 8'h00);
        idle();
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("emit_one", 32'(pix_data), 32'h010000);
        idle();

        // ADD wrap: FF + 01
        issue(4'd8, 4'd0, 4'd0, 4'd1, 8'hFF);
        issue(4'd8, 4'd0, 4'd0, 4'd2, 8'h01);
        issue(4'd1, 4'd1, 4'd2, 4'd3, 8'h00);
        check("add_wrap_cc", 32'(cc), 32'b0110);
        check("model_add_wrap_cc", 32'(m_cc), 32'b0110);
        idle();

        // Dependent INC chain
        issue(4'd8, 4'd0, 4'd0, 4'd4, 8'h00);
        idle();
        t0 = cyc;
        for (int i = 0; i < 4; i++) issue(4'd10, 4'd4, 4'd0, 4'd4, 8'h00);
`ifdef DPU_FORWARD_EN
        check("inc_chain_cycles", 32'(cyc - t0), 32'd4);
`else
        check("inc_chain_cycles", 32'(cyc - t0), 32'd7);
`endif
        issue(4'd9, 4'd4, 4'd0, 4'd9, 8'h00);
        idle();
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("inc_chain_r4", 32'(pix_data[23:16]), 32'h04);
        idle();

        // Stalled pixel port
        pix_ready = 1'b0;
        issue(4'd8, 4'd0, 4'd0, 4'd9, 8'h05);
        issue(4'd8, 4'd0, 4'd0, 4'd10, 8'h07);
        issue(4'd8, 4'd0, 4'd0, 4'd11, 8'hA3);
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("emit_pixel", 32'(pix_data), 32'h0507A3);
        check("model_emit_pixel", 32'(m_pd), 32'h0507A3);
        issue(4'd8, 4'd0, 4'd0, 4'd11, 8'h11);
        in_valid = 1'b1; op = 4'd12;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("emit_stall_ready", 32'(in_ready), 32'h0);
            check("emit_stall_hold", 32'(pix_data), 32'h0507A3);
        end
        pix_ready = 1'b1;
        #1;
        check("drain_frees_slot", 32'(in_ready), 32'h1);
        cycle();
        check("second_emit_accepted", 32'(m_acc), 32'h1);
        check("no_bubble_valid", 32'(pix_valid), 32'h1);
        check("second_emit_data", 32'(pix_data), 32'h050711);
        idle();

        // Signed overflow on INC, CMP with no write
        issue(4'd8, 4'd0, 4'd0, 4'd5, 8'h7F);
        issue(4'd10, 4'd5, 4'd0, 4'd6, 8'h00);
        check("inc_ovf_cc", 32'(cc), 32'b1001);
        issue(4'd13, 4'd5, 4'd5, 4'd6, 8'h00);
        check("cmp_eq_cc", 32'(cc), 32'b0110);
        issue(4'd9, 4'd6, 4'd0, 4'd9, 8'h00);
        idle();
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("cmp_no_write", 32'(pix_data), 32'h800711);

        // Reset right after an ADD accept, pixel held
        pix_ready = 1'b0;
        issue(4'd1, 4'd9, 4'd12, 4'd9, 8'h00);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_cc", 32'(cc), 32'h0);
        pix_ready = 1'b1;
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("rst_regs_zero", 32'(pix_data), 32'h0);
        issue(4'd9, 4'd12, 4'd0, 4'd9, 8'h00);
        idle();
        issue(4'd12, 4'd0, 4'd0, 4'd0, 8'h00);
        check("rst_one_reg", 32'(pix_data), 32'h010000);
        idle();

        // Random traffic, pointer-heavy around the pixel registers
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 4'($urandom_range(0, 15));
            a_sel     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 12)) : 4'($urandom_range(0, 15));
            b_sel     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 12)) : 4'($urandom_range(0, 15));
            r_sel     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(8, 12)) : 4'($urandom_range(0, 15));
            mdata     = 8'($urandom_range(0, 255));
            pix_ready = ($urandom_range(0, 1) == 0);
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0; pix_ready = 1'b1;
        cycle(); cycle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
